// File: rtl/skinny_masking_pkg.sv
// Shared constants, FSM state type and latency helper for the masked SKINNY-64 S-box layer.
package skinny_masking_pkg;

  localparam int unsigned SHARES   = 3;
  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } layer_state_t;

  // Cycles from the start edge to the done pulse.
  function automatic int unsigned total_latency(input int unsigned nibbles,
                                                input int unsigned sbox_lat);
    return nibbles + sbox_lat + 1;
  endfunction

endpackage

// File: rtl/skinny_sbox_valid_pipe.sv
// Valid shift register matching the attached S-box pipeline depth; emits the capture strobe.
module skinny_sbox_valid_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic vld_in,
  output logic strobe
);

  logic [DEPTH-1:0] vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld <= (vld << 1) | DEPTH'(vld_in);
    end
  end

  assign strobe = vld[DEPTH-1];

endmodule

// File: rtl/skinny_sbox_layer_ctrl.sv
// Sequences one SKINNY-64 S-box layer over a 3-share masked state through a shared nibble S-box.
module skinny_sbox_layer_ctrl
  import skinny_masking_pkg::*;
#(
  parameter int unsigned SBOX_LAT = 1,
  parameter int unsigned NIBBLES  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*NIBBLES-1:0]  state_in1,
  input  logic [4*NIBBLES-1:0]  state_in2,
  input  logic [4*NIBBLES-1:0]  state_in3,
  output logic                  busy,
  output logic                  done,
  output logic [4*NIBBLES-1:0]  state_out1,
  output logic [4*NIBBLES-1:0]  state_out2,
  output logic [4*NIBBLES-1:0]  state_out3,
  output logic [3:0]            sb_in1,
  output logic [3:0]            sb_in2,
  output logic [3:0]            sb_in3,
  input  logic [3:0]            sb_out1,
  input  logic [3:0]            sb_out2,
  input  logic [3:0]            sb_out3
);

  localparam int unsigned W = NIBBLE_W * NIBBLES;
  localparam logic [4:0] LAST_NIB = 5'(NIBBLES - 1);

  layer_state_t state;
  logic [4:0]   issue_cnt;
  logic [4:0]   cap_cnt;
  logic         launch;
  logic         issuing;
  logic         cap_stb;

  logic [W-1:0]        share_in  [SHARES];
  logic [W-1:0]        share_out [SHARES];
  logic [NIBBLE_W-1:0] nib_issue [SHARES];
  logic [NIBBLE_W-1:0] nib_ret   [SHARES];

  assign launch  = (state == IDLE) && start;
  assign issuing = (state == ISSUE);
  assign busy    = (state == ISSUE) || (state == DRAIN);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            issue_cnt <= '0;
          end
        end
        ISSUE: begin
          issue_cnt <= issue_cnt + 5'd1;
          if (issue_cnt == LAST_NIB) state <= DRAIN;
        end
        DRAIN: begin
          if (cap_stb && (cap_cnt == LAST_NIB)) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Captures can begin while still issuing, so this counter runs independently of the FSM case.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_cnt <= '0;
    end else if (launch) begin
      cap_cnt <= '0;
    end else if (cap_stb) begin
      cap_cnt <= cap_cnt + 5'd1;
    end
  end

  skinny_sbox_valid_pipe #(
    .DEPTH(SBOX_LAT)
  ) u_valid_pipe (
    .clk    (clk),
    .rst    (rst),
    .vld_in (issuing),
    .strobe (cap_stb)
  );

  assign share_in[0] = state_in1;
  assign share_in[1] = state_in2;
  assign share_in[2] = state_in3;
  assign nib_ret[0]  = sb_out1;
  assign nib_ret[1]  = sb_out2;
  assign nib_ret[2]  = sb_out3;

  // Identical per-share slice; selects come only from the counters, never from share data.
  for (genvar s = 0; s < SHARES; s++) begin : g_share
    logic [W-1:0]        reg_q;
    logic [W-1:0]        out_q;
    logic [NIBBLE_W-1:0] issue_nib;

    always_ff @(posedge clk) begin
      if (rst) begin
        reg_q <= '0;
      end else if (launch) begin
        reg_q <= share_in[s];
      end
    end

    always_comb begin
      issue_nib = '0;
      for (int unsigned k = 0; k < NIBBLES; k++) begin
        if (issuing && (issue_cnt == 5'(k))) issue_nib = reg_q[NIBBLE_W*k +: NIBBLE_W];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q <= '0;
      end else if (cap_stb) begin
        for (int unsigned k = 0; k < NIBBLES; k++) begin
          if (cap_cnt == 5'(k)) out_q[NIBBLE_W*k +: NIBBLE_W] <= nib_ret[s];
        end
      end
    end

    assign nib_issue[s] = issue_nib;
    assign share_out[s] = out_q;
  end

  assign sb_in1     = nib_issue[0];
  assign sb_in2     = nib_issue[1];
  assign sb_in3     = nib_issue[2];
  assign state_out1 = share_out[0];
  assign state_out2 = share_out[1];
  assign state_out3 = share_out[2];

endmodule

// File: tb/tb_skinny_sbox_layer_ctrl.sv
// Self-checking bench: two controllers (S-box latency 1 and 4) against a timeline/result model.
module tb_skinny_sbox_layer_ctrl;
  import skinny_masking_pkg::*;

  localparam int NIB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] in1, in2, in3;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ts;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'hF7E4D583B2A1096C;
    return tbl[4*x +: 4];
  endfunction

  function automatic logic [63:0] layer(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < NIB; i++) r[4*i +: 4] = sbox(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [11:0] sbox_shared(input logic [3:0] a, input logic [3:0] b,
                                              input logic [3:0] c, input logic [3:0] m1,
                                              input logic [3:0] m2);
    return {sbox(a ^ b ^ c) ^ m1 ^ m2, m1, m2};
  endfunction

  function automatic logic [11:0] nib3(input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] c, input int k);
    return {a[4*k +: 4], b[4*k +: 4], c[4*k +: 4]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 4;

    logic        busy, done;
    logic [63:0] o1, o2, o3;
    logic [3:0]  si1, si2, si3, so1, so2, so3;
    logic [11:0] pipe [LAT];

    bit          has_run = 1'b0;
    int          t_run = 0;
    logic [63:0] l1 = '0, l2 = '0, l3 = '0;
    logic [63:0] e1 = '0, e2 = '0, e3 = '0;
    int          last_done = 0;
    int          ndone = 0;

    skinny_sbox_layer_ctrl #(
      .SBOX_LAT(LAT),
      .NIBBLES (NIB)
    ) dut (
      .clk(clk), .rst(rst), .start(start),
      .state_in1(in1), .state_in2(in2), .state_in3(in3),
      .busy(busy), .done(done),
      .state_out1(o1), .state_out2(o2), .state_out3(o3),
      .sb_in1(si1), .sb_in2(si2), .sb_in3(si3),
      .sb_out1(so1), .sb_out2(so2), .sb_out3(so3)
    );

    always @(posedge clk) begin
      pipe[0] <= sbox_shared(si1, si2, si3, 4'($urandom), 4'($urandom));
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {so1, so2, so3} = pipe[LAT-1];

    // Reference timeline: a run started at edge t issues cycles t+1..t+16 and is idle again from t+NIB+LAT+2.
    always @(posedge clk) begin
      if (rst) begin
        has_run <= 1'b0;
        e1 <= '0; e2 <= '0; e3 <= '0;
      end else begin
        if (start && (!has_run || cyc >= t_run + NIB + LAT + 2)) begin
          has_run <= 1'b1;
          t_run   <= cyc;
          l1 <= in1; l2 <= in2; l3 <= in3;
        end
        if (has_run && cyc >= t_run + 1 + LAT && cyc <= t_run + NIB + LAT) begin
          e1[4*(cyc - t_run - 1 - LAT) +: 4] <= so1;
          e2[4*(cyc - t_run - 1 - LAT) +: 4] <= so2;
          e3[4*(cyc - t_run - 1 - LAT) +: 4] <= so3;
        end
      end
    end

    always @(negedge clk) begin
      if (done) begin
        last_done <= cyc;
        ndone     <= ndone + 1;
      end
      if (cyc >= 1) begin
        chk($sformatf("lat%0d_busy", LAT), busy,
            has_run && cyc >= t_run + 1 && cyc <= t_run + NIB + LAT);
        chk($sformatf("lat%0d_done", LAT), done, has_run && cyc == t_run + NIB + LAT + 1);
        chk($sformatf("lat%0d_sb_in", LAT), {si1, si2, si3},
            (has_run && cyc >= t_run + 1 && cyc <= t_run + NIB) ?
              nib3(l1, l2, l3, cyc - t_run - 1) : 12'h000);
        chk($sformatf("lat%0d_out1", LAT), o1, e1);
        chk($sformatf("lat%0d_out2", LAT), o2, e2);
        chk($sformatf("lat%0d_out3", LAT), o3, e3);
        if (has_run && cyc == t_run + NIB + LAT + 1)
          chk($sformatf("lat%0d_recombined", LAT), o1 ^ o2 ^ o3, layer(l1 ^ l2 ^ l3));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    in1 = '0; in2 = '0; in3 = '0;
    tick(3);
    rst = 1'b0;
    tick(2);

    chk("model_layer_vec", layer(64'h0123456789ABCDEF), 64'hC6901A2B385D4E7F);
    chk("model_layer_ones", layer(64'hFFFFFFFFFFFFFFFF), 64'hFFFFFFFFFFFFFFFF);
    chk("model_latency", 64'(total_latency(16, 1)), 64'd18);
    chk("reset_out_lat1", lane[0].o1 | lane[0].o2 | lane[0].o3, 64'h0);

    // Plain unshared input in share 1
    in1 = 64'h0123456789ABCDEF; in2 = '0; in3 = '0;
    start = 1'b1; ts = cyc;
    tick(1);
    start = 1'b0;
    tick(30);
    chk("a_done_cycle_lat1", 64'(lane[0].last_done - ts), 64'd18);
    chk("a_done_cycle_lat4", 64'(lane[1].last_done - ts), 64'd21);
    chk("a_result_lat1", lane[0].o1 ^ lane[0].o2 ^ lane[0].o3, 64'hC6901A2B385D4E7F);
    chk("a_result_lat4", lane[1].o1 ^ lane[1].o2 ^ lane[1].o3, 64'hC6901A2B385D4E7F);

    // Random sharing of all-ones
    in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom};
    in3 = ~(in1 ^ in2);
    start = 1'b1; ts = cyc;
    tick(1);
    start = 1'b0;
    tick(30);
    chk("b_done_cycle_lat4", 64'(lane[1].last_done - ts), 64'd21);
    chk("b_result_lat4", lane[1].o1 ^ lane[1].o2 ^ lane[1].o3, 64'hFFFFFFFFFFFFFFFF);

    // start re-asserted while busy must be ignored
    in1 = 64'h0123456789ABCDEF; in2 = '0; in3 = '0;
    start = 1'b1; ts = cyc;
    tick(1);
    start = 1'b0;
    tick(4);
    start = 1'b1;
    tick(6);
    start = 1'b0;
    tick(30);
    chk("c_done_cycle_lat1", 64'(lane[0].last_done - ts), 64'd18);
    chk("c_result_lat1", lane[0].o1 ^ lane[0].o2 ^ lane[0].o3, 64'hC6901A2B385D4E7F);

    // Reset in cycle 9 of a run, restart in cycle 12
    in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom}; in3 = {$urandom, $urandom};
    start = 1'b1; ts = cyc;
    tick(1);
    start = 1'b0;
    tick(8);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("d_busy_after_rst", lane[0].busy, 64'd0);
    chk("d_out_after_rst", lane[0].o1 | lane[0].o2 | lane[0].o3, 64'h0);
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(30);
    chk("d_done_cycle_lat1", 64'(lane[0].last_done - ts), 64'd30);

    // Back-to-back runs with start held high; second run sees new inputs
    in1 = 64'h0123456789ABCDEF; in2 = 64'h5A5A5A5A5A5A5A5A; in3 = 64'h5A5A5A5A5A5A5A5A;
    ts = lane[0].ndone;
    start = 1'b1;
    tick(1);
    in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom};
    in3 = ~(in1 ^ in2);
    tick(29);
    start = 1'b0;
    tick(30);
    chk("e_done_count_lat1", 64'(lane[0].ndone - ts), 64'd2);
    chk("e_result_lat1", lane[0].o1 ^ lane[0].o2 ^ lane[0].o3, 64'hFFFFFFFFFFFFFFFF);
    chk("e_result_lat4", lane[1].o1 ^ lane[1].o2 ^ lane[1].o3, 64'hFFFFFFFFFFFFFFFF);

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
